fb_access_arbiter: RTL and testbench
====================================

Name: fb_access_arbiter

Overview:
- Shares the 1bpp 1024x512 framebuffer BRAM array between two requesters: display scanout (read-only, latency-critical) and host/draw engine (read and write).
- Translates each granted (x, y) request into bank, block and line address, drives one BRAM port, and steers the 1-cycle-latency read data back to the right requester.
- Sits between the video timing/scanout pipeline and the BRAM bank array.

Parameters:
- WORD_W, 16, pixels per BRAM word (1bpp); x[9:4] selects the word.
- ADDR_W, 10, BRAM word address width: {y[3:0], x[9:4]}.
- STARVE_LIMIT, 8, consecutive cycles the host may be denied before it is forced through.
- CNT_W, 16, statistics counter width (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- scan_req  in  1  scanout read request; level, one word per cycle while high
- scan_x  in  10  scanout pixel x; bits [3:0] ignored
- scan_y  in  9  scanout line
- scan_gnt  out  1  scanout request accepted this cycle
- scan_rvalid  out  1  scanout read data valid
- scan_rdata  out  16  scanout read word
- host_valid  in  1  host request valid; held with payload until host_ready
- host_ready  out  1  host request accepted this cycle
- host_we  in  1  1 = write, 0 = read
- host_x  in  10  host pixel x; bits [3:0] ignored
- host_y  in  9  host line
- host_wdata  in  16  host write word
- host_wmask  in  16  per-pixel write mask; 1 = write the pixel
- host_rvalid  out  1  host read data valid
- host_rdata  out  16  host read word
- bram_bank  out  4  one-hot bank select, from y[8:7] (00 gives 0001, 11 gives 1000)
- bram_block  out  3  BRAM within the bank, equal to y[6:4]
- bram_addr  out  10  {y[3:0], x[9:4]}
- bram_en  out  1  port enable
- bram_we  out  1  write enable
- bram_wdata  out  16  write data
- bram_wmask  out  16  write mask
- bram_rdata  in  16  read data, valid 1 cycle after bram_en with bram_we low

Behaviour:
- Reset values: all outputs 0, except bram_bank = 4'b0001. The starvation counter and pending-read tag are cleared.
- Arbitration is combinational within the cycle. The BRAM outputs are registered, so a request granted in cycle N drives the BRAM in N+1.
- Priority: scan_req wins. The only exception is when starve_cnt == STARVE_LIMIT and host_valid is high; then the host wins and scan_gnt = 0.
- starve_cnt behaviour:
  - increments while host_valid is high and not granted;
  - clears on a host grant, or when host_valid is low;
  - saturates at STARVE_LIMIT.
- A denied scan_req is not queued. The scanout side re-presents the request. A missed scanout word is its underflow concern.
- Handshake: host_ready = grant; host_valid/host_ready follow valid/ready rules. The payload may change only after acceptance.
- When nothing is granted, the registered outputs are forced as follows:
  - bram_en = 0 and bram_we = 0;
  - the address outputs hold their last value.
- Read return:
  - The tag register records the requester that owns the issued read (SCAN, HOST or NONE).
  - Two cycles after grant, scan_rvalid or host_rvalid pulses for 1 cycle, with rdata registered from bram_rdata.
  - Total read latency from grant to rvalid is 2 cycles. Back-to-back reads are fully pipelined.
  - Host writes produce no rvalid.
- State (tag) machine: NONE/SCAN/HOST, updated every cycle from the issued operation. No multi-cycle states; throughput is 1 access per cycle.
- Simultaneous requests:
  - scan and host both present, not starved: scanout is granted and starve_cnt increments.
  - Host starved: host is granted once, then starve_cnt = 0 and scanout priority resumes.
- Boundaries:
  - x = 1023, y = 511 maps to bank 1000, block 7, addr 0x3FF.
  - x = 0, y = 0 maps to bank 0001, block 0, addr 0.
- Asynchronous reset mid-read: the in-flight rvalid is dropped and is never emitted after reset.

Optional Feature:
- FB_ARB_STATS_EN defined adds these ports:
  - stat_scan_cnt, stat_host_cnt, stat_conflict_cnt (out, CNT_W each): counts of scan grants, host grants and cycles in which both requested;
  - stat_clr (in, 1): synchronous clear.
- The counters saturate at all-ones and reset to 0.
- Without the macro, the ports and logic are absent and the core behaviour is identical.

Decomposition:
- Package fb_pkg holds:
  - FB_WIDTH = 1024, FB_HEIGHT = 512, WORD_W, ADDR_W;
  - typedef fb_req_t {we, x, y, wdata, wmask};
  - enum fb_owner_e {OWN_NONE, OWN_SCAN, OWN_HOST}.
- One sub-module, fb_xy_map: a pure combinational (x, y) to {bank, block, addr} mapping, reused by other framebuffer clients.

Test Plan:
- Reset with rst high mid-stream -> all outputs 0, bram_bank = 0001. A read issued 1 cycle before reset produces no rvalid.
- Scanout alone, x = 0, 16, 32 on y = 130 in consecutive cycles -> scan_gnt stays high, bram_bank = 0010, block = 0, addr = 0x080, 0x081, 0x082. scan_rvalid trails each grant by 2 cycles with the matching data.
- Host write x = 1023, y = 511, wdata = 0xA5A5, mask = 0xFFFF with scan idle -> host_ready in cycle 0; bram_we = 1, bank = 1000, block = 7, addr = 0x3FF in cycle 1; no host_rvalid.
- Continuous scan_req with host read pending -> host denied for 8 cycles, granted on the 9th with scan_gnt = 0 that cycle. host_rvalid 2 cycles later; scanout granted again the next cycle.
- Alternating scan and host reads in back-to-back cycles -> rvalid pulses are routed to the correct requester in order, and data never crosses between requesters.
- FB_ARB_STATS_EN: 10 overlapping cycles -> stat_conflict_cnt = 10 and the grant counts sum to 10. stat_clr zeroes all counters next cycle.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: geometry, request payload and read-owner tags.
// Imported by the arbiter, its request interface and the (x, y) mapper.
package fb_pkg;

  localparam int FB_WIDTH  = 1024;
  localparam int FB_HEIGHT = 512;
  localparam int WORD_W    = 16;
  localparam int ADDR_W    = 10;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;

  // One framebuffer access as presented to the BRAM port.
  typedef struct packed {
    logic              we;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] wmask;
  } fb_req_t;

  // Which requester owns the read currently in flight to the BRAM.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SCAN = 2'd1,
    OWN_HOST = 2'd2
  } fb_owner_e;

  // y[8:7] selects one of four banks; encoded one-hot.
  function automatic logic [3:0] fb_bank_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/fb_access_arbiter_if.sv
// Requester-side bus of the framebuffer arbiter: scanout read port and host
// read/write port.
//
// Handshake rules:
//   scan: scan_req is a level; each cycle it is high with scan_gnt high one word
//         is accepted. A cycle with scan_req high and scan_gnt low is dropped,
//         not queued; the scanout side re-presents it.
//   host: valid/ready. host_valid, once raised, is held with a stable payload
//         (host_we/x/y/wdata/wmask) until a cycle where host_ready is high; that
//         cycle is the transfer. host_ready may be high only when host_valid is.
//   read return: scan_rvalid/host_rvalid pulse one cycle per accepted read, two
//         cycles after the accepting cycle, in acceptance order; rdata is only
//         meaningful (and otherwise zero) while the matching rvalid is high.
interface fb_access_arbiter_if;
  import fb_pkg::*;

  logic              scan_req;
  logic [X_W-1:0]    scan_x;
  logic [Y_W-1:0]    scan_y;
  logic              scan_gnt;
  logic              scan_rvalid;
  logic [WORD_W-1:0] scan_rdata;

  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [X_W-1:0]    host_x;
  logic [Y_W-1:0]    host_y;
  logic [WORD_W-1:0] host_wdata;
  logic [WORD_W-1:0] host_wmask;
  logic              host_rvalid;
  logic [WORD_W-1:0] host_rdata;

  // Requester side (scanout pipeline and host/draw engine).
  modport master (
    output scan_req, scan_x, scan_y,
    input  scan_gnt, scan_rvalid, scan_rdata,
    output host_valid, host_we, host_x, host_y, host_wdata, host_wmask,
    input  host_ready, host_rvalid, host_rdata
  );

  // Arbiter side.
  modport slave (
    input  scan_req, scan_x, scan_y,
    output scan_gnt, scan_rvalid, scan_rdata,
    input  host_valid, host_we, host_x, host_y, host_wdata, host_wmask,
    output host_ready, host_rvalid, host_rdata
  );

endinterface

// File: rtl/fb_xy_map.sv
// Pure combinational pixel (x, y) to BRAM location mapping for the 1bpp
// 1024x512 framebuffer: bank from y[8:7] (one-hot), block from y[6:4],
// word address {y[3:0], x[9:4]}. x[3:0] selects a pixel inside the word and
// does not affect the location.
module fb_xy_map
  import fb_pkg::*;
(
  input  logic [X_W-1:0]    x_i,
  input  logic [Y_W-1:0]    y_i,
  output logic [3:0]        bank_o,
  output logic [2:0]        block_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic unused_x_lsb;

  assign bank_o       = fb_bank_onehot(y_i[8:7]);
  assign block_o      = y_i[6:4];
  assign addr_o       = {y_i[3:0], x_i[9:4]};
  assign unused_x_lsb = ^x_i[3:0];

endmodule

// File: rtl/fb_access_arbiter.sv
// Framebuffer BRAM port arbiter between display scanout (priority reads) and
// the host/draw engine (reads and masked writes). Grants are decided
// combinationally, the BRAM port is driven from registers one cycle later, and
// read data is steered back to its owner two cycles after the grant.
// The host is forced through after STARVE_LIMIT consecutive denials.
// Optional build macro FB_ARB_STATS_EN adds saturating grant/conflict counters.
module fb_access_arbiter
  import fb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 16
)(
  input  logic                clk,
  input  logic                rst,
  fb_access_arbiter_if.slave  req_if,
  output logic [3:0]          bram_bank,
  output logic [2:0]          bram_block,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic                bram_en,
  output logic                bram_we,
  output logic [WORD_W-1:0]   bram_wdata,
  output logic [WORD_W-1:0]   bram_wmask,
  input  logic [WORD_W-1:0]   bram_rdata,
`ifdef FB_ARB_STATS_EN
  input  logic                stat_clr,
  output logic [CNT_W-1:0]    stat_scan_cnt,
  output logic [CNT_W-1:0]    stat_host_cnt,
  output logic [CNT_W-1:0]    stat_conflict_cnt,
`endif
  output fb_owner_e           dbg_owner
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                host_force;
  logic                scan_gnt;
  logic                host_gnt;
  fb_req_t             sel_req;

  logic [3:0]          map_bank;
  logic [2:0]          map_block;
  logic [ADDR_W-1:0]   map_addr;

  logic [3:0]          bank_q;
  logic [2:0]          block_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                en_q;
  logic                we_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   wmask_q;
  fb_owner_e           owner_q;
  logic                scan_rvalid_q;
  logic                host_rvalid_q;

  // Scanout wins unless the host has waited STARVE_LIMIT cycles in a row.
  assign host_force = req_if.host_valid && (starve_q == STARVE_MAX);
  assign scan_gnt   = req_if.scan_req && !host_force;
  assign host_gnt   = req_if.host_valid && !scan_gnt;

  // Host denial counter: counts consecutive denied cycles, clears otherwise.
  always_comb begin
    starve_d = '0;
    if (req_if.host_valid && !host_gnt) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  // Payload of whichever requester is granted (scan payload when none is).
  always_comb begin
    sel_req.we    = 1'b0;
    sel_req.x     = req_if.scan_x;
    sel_req.y     = req_if.scan_y;
    sel_req.wdata = '0;
    sel_req.wmask = '0;
    if (host_gnt) begin
      sel_req.we    = req_if.host_we;
      sel_req.x     = req_if.host_x;
      sel_req.y     = req_if.host_y;
      sel_req.wdata = req_if.host_wdata;
      sel_req.wmask = req_if.host_wmask;
    end
  end

  fb_xy_map u_xy_map (
    .x_i     (sel_req.x),
    .y_i     (sel_req.y),
    .bank_o  (map_bank),
    .block_o (map_block),
    .addr_o  (map_addr)
  );

  // Issue stage and read-owner tag machine: registers the granted access onto
  // the BRAM port, tags reads with their owner, and one cycle later turns the
  // tag into the owner's rvalid pulse. Reset drops any read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q        <= 4'b0001;
      block_q       <= '0;
      addr_q        <= '0;
      en_q          <= 1'b0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      wmask_q       <= '0;
      owner_q       <= OWN_NONE;
      scan_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      scan_rvalid_q <= (owner_q == OWN_SCAN);
      host_rvalid_q <= (owner_q == OWN_HOST);
      if (scan_gnt || host_gnt) begin
        bank_q  <= map_bank;
        block_q <= map_block;
        addr_q  <= map_addr;
        en_q    <= 1'b1;
        we_q    <= sel_req.we;
        wdata_q <= sel_req.wdata;
        wmask_q <= sel_req.wmask;
        if (sel_req.we)    owner_q <= OWN_NONE;
        else if (host_gnt) owner_q <= OWN_HOST;
        else               owner_q <= OWN_SCAN;
      end else begin
        en_q    <= 1'b0;
        we_q    <= 1'b0;
        owner_q <= OWN_NONE;
      end
    end
  end

  assign req_if.scan_gnt    = scan_gnt;
  assign req_if.host_ready  = host_gnt;
  assign req_if.scan_rvalid = scan_rvalid_q;
  assign req_if.host_rvalid = host_rvalid_q;
  // The BRAM output register supplies the data; it is steered to its owner
  // and zero elsewhere so a word never appears on the other requester's bus.
  assign req_if.scan_rdata  = scan_rvalid_q ? bram_rdata : '0;
  assign req_if.host_rdata  = host_rvalid_q ? bram_rdata : '0;

  assign bram_bank  = bank_q;
  assign bram_block = block_q;
  assign bram_addr  = addr_q;
  assign bram_en    = en_q;
  assign bram_we    = we_q;
  assign bram_wdata = wdata_q;
  assign bram_wmask = wmask_q;
  assign dbg_owner  = owner_q;

`ifdef FB_ARB_STATS_EN
  logic [CNT_W-1:0] scan_cnt_q;
  logic [CNT_W-1:0] host_cnt_q;
  logic [CNT_W-1:0] conflict_cnt_q;

  // Saturating usage counters with synchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q     <= '0;
      host_cnt_q     <= '0;
      conflict_cnt_q <= '0;
    end else if (stat_clr) begin
      scan_cnt_q     <= '0;
      host_cnt_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (scan_gnt && (scan_cnt_q != '1)) scan_cnt_q <= scan_cnt_q + CNT_W'(1);
      if (host_gnt && (host_cnt_q != '1)) host_cnt_q <= host_cnt_q + CNT_W'(1);
      if (req_if.scan_req && req_if.host_valid && (conflict_cnt_q != '1))
        conflict_cnt_q <= conflict_cnt_q + CNT_W'(1);
    end
  end

  assign stat_scan_cnt     = scan_cnt_q;
  assign stat_host_cnt     = host_cnt_q;
  assign stat_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. The BRAM model returns
// a word derived from its location one cycle after a read enable.
module tb_fb_access_arbiter;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  bram_bank;
  logic [2:0]  bram_block;
  logic [9:0]  bram_addr;
  logic        bram_en;
  logic        bram_we;
  logic [15:0] bram_wdata;
  logic [15:0] bram_wmask;
  logic [15:0] bram_rdata = 16'h0;
  fb_owner_e   dbg_owner;
  int          checks = 0;
  int          errors = 0;
`ifdef FB_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_scan_cnt;
  logic [15:0] stat_host_cnt;
  logic [15:0] stat_conflict_cnt;
`endif

  fb_access_arbiter_if bus();

  // Clock generation.
  always #5 clk = ~clk;

  fb_access_arbiter #(.STARVE_LIMIT(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_if     (bus),
    .bram_bank  (bram_bank),
    .bram_block (bram_block),
    .bram_addr  (bram_addr),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_wdata (bram_wdata),
    .bram_wmask (bram_wmask),
    .bram_rdata (bram_rdata),
`ifdef FB_ARB_STATS_EN
    .stat_clr          (stat_clr),
    .stat_scan_cnt     (stat_scan_cnt),
    .stat_host_cnt     (stat_host_cnt),
    .stat_conflict_cnt (stat_conflict_cnt),
`endif
    .dbg_owner  (dbg_owner)
  );

  // BRAM model: registered read, word = {addr, block, 3'b101}.
  always @(posedge clk) begin
    if (bram_en && !bram_we) bram_rdata <= {bram_addr, bram_block, 3'b101};
  end

  // Word the BRAM model holds for pixel (x, y), worked out from x and y.
  function automatic logic [15:0] exp_word(input logic [9:0] x, input logic [8:0] y);
    return {y[3:0], x[9:4], y[6:4], 3'b101};
  endfunction

  task automatic idle();
    bus.scan_req   = 1'b0;
    bus.scan_x     = '0;
    bus.scan_y     = '0;
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_x     = '0;
    bus.host_y     = '0;
    bus.host_wdata = '0;
    bus.host_wmask = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.scan_gnt, bus.scan_rvalid, bus.host_ready, bus.host_rvalid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_handshake: got %b want 0000",
               {bus.scan_gnt, bus.scan_rvalid, bus.host_ready, bus.host_rvalid});
    end
    checks++;
    if ({bus.scan_rdata, bus.host_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 0", {bus.scan_rdata, bus.host_rdata});
    end
    checks++;
    if ({bram_en, bram_we, bram_bank, bram_block, bram_addr} !== {2'b00, 4'b0001, 3'd0, 10'd0}) begin
      errors++;
      $display("FAIL reset_bram_port: got %b want %b",
               {bram_en, bram_we, bram_bank, bram_block, bram_addr}, {2'b00, 4'b0001, 3'd0, 10'd0});
    end
    checks++;
    if ({bram_wdata, bram_wmask} !== 32'h0) begin
      errors++;
      $display("FAIL reset_bram_data: got %h want 0", {bram_wdata, bram_wmask});
    end
    checks++;
    if (dbg_owner !== OWN_NONE) begin
      errors++;
      $display("FAIL reset_owner: got %0d want 0", dbg_owner);
    end
    rst = 1'b0;
    // Issue a read, then reset while it is in flight.
    next_cycle();
    bus.scan_req = 1'b1;
    bus.scan_x   = 10'd1023;
    bus.scan_y   = 9'd511;
    next_cycle();
    bus.scan_req = 1'b0;
    checks++;
    if ({bram_en, bram_addr} !== {1'b1, 10'h3FF}) begin
      errors++;
      $display("FAIL inflight_issue: got %b want %b", {bram_en, bram_addr}, {1'b1, 10'h3FF});
    end
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bram_en, bram_bank, bram_addr, dbg_owner} !== {1'b0, 4'b0001, 10'd0, OWN_NONE}) begin
      errors++;
      $display("FAIL midreset_state: got %b want %b", {bram_en, bram_bank, bram_addr, dbg_owner},
               {1'b0, 4'b0001, 10'd0, OWN_NONE});
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.scan_rvalid, bus.host_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL midreset_no_rvalid: cycle %0d got %b want 00", k,
                 {bus.scan_rvalid, bus.host_rvalid});
      end
    end
  endtask

  task automatic test_scan_stream();
    logic [15:0] exp_d;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      bus.scan_req = (k < 3);
      bus.scan_x   = 10'(16 * k);
      bus.scan_y   = 9'd130;
      @(negedge clk);
      checks++;
      if (bus.scan_gnt !== (k < 3)) begin
        errors++;
        $display("FAIL scan_gnt: cycle %0d got %b want %b", k, bus.scan_gnt, (k < 3));
      end
      if (k >= 1 && k <= 3) begin
        checks++;
        if ({bram_en, bram_we, bram_bank, bram_block, bram_addr} !==
            {1'b1, 1'b0, 4'b0010, 3'd0, 10'h080 + 10'(k - 1)}) begin
          errors++;
          $display("FAIL scan_bram_port: cycle %0d got %b want %b", k,
                   {bram_en, bram_we, bram_bank, bram_block, bram_addr},
                   {1'b1, 1'b0, 4'b0010, 3'd0, 10'h080 + 10'(k - 1)});
        end
      end
      if (k == 1) begin
        checks++;
        if (dbg_owner !== OWN_SCAN) begin
          errors++;
          $display("FAIL scan_owner: got %0d want 1", dbg_owner);
        end
      end
      checks++;
      if (bus.scan_rvalid !== (k >= 2 && k <= 4)) begin
        errors++;
        $display("FAIL scan_rvalid: cycle %0d got %b want %b", k, bus.scan_rvalid, (k >= 2 && k <= 4));
      end
      if (k >= 2 && k <= 4) begin
        exp_d = exp_word(10'(16 * (k - 2)), 9'd130);
        checks++;
        if (bus.scan_rdata !== exp_d) begin
          errors++;
          $display("FAIL scan_rdata: cycle %0d got %h want %h", k, bus.scan_rdata, exp_d);
        end
      end
    end
    idle();
  endtask

  task automatic test_host_write();
    next_cycle();
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_x     = 10'd1023;
    bus.host_y     = 9'd511;
    bus.host_wdata = 16'hA5A5;
    bus.host_wmask = 16'hFFFF;
    @(negedge clk);
    checks++;
    if ({bus.host_ready, bus.scan_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL hwr_ready: got %b want 10", {bus.host_ready, bus.scan_gnt});
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if ({bram_en, bram_we, bram_bank, bram_block, bram_addr} !== {1'b1, 1'b1, 4'b1000, 3'd7, 10'h3FF}) begin
      errors++;
      $display("FAIL hwr_bram_port: got %b want %b", {bram_en, bram_we, bram_bank, bram_block, bram_addr},
               {1'b1, 1'b1, 4'b1000, 3'd7, 10'h3FF});
    end
    checks++;
    if ({bram_wdata, bram_wmask} !== {16'hA5A5, 16'hFFFF}) begin
      errors++;
      $display("FAIL hwr_bram_data: got %h want a5a5ffff", {bram_wdata, bram_wmask});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.host_rvalid, bus.scan_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL hwr_no_rvalid: cycle %0d got %b want 00", k, {bus.host_rvalid, bus.scan_rvalid});
      end
      if (k == 0) begin
        checks++;
        if ({bram_en, bram_we, bram_addr} !== {1'b0, 1'b0, 10'h3FF}) begin
          errors++;
          $display("FAIL idle_hold: got %b want %b", {bram_en, bram_we, bram_addr}, {1'b0, 1'b0, 10'h3FF});
        end
      end
    end
  endtask

  task automatic test_starve();
    logic        exp_sr;
    logic [15:0] exp_d;
    for (int k = 0; k < 14; k++) begin
      next_cycle();
      bus.scan_req   = (k <= 11);
      bus.scan_x     = 10'(16 * k);
      bus.scan_y     = 9'd40;
      bus.host_valid = (k <= 8);
      bus.host_we    = 1'b0;
      bus.host_x     = 10'd64;
      bus.host_y     = 9'd5;
      @(negedge clk);
      checks++;
      if ({bus.scan_gnt, bus.host_ready} !== {(k <= 11 && k != 8), (k == 8)}) begin
        errors++;
        $display("FAIL starve_grant: cycle %0d got %b want %b", k, {bus.scan_gnt, bus.host_ready},
                 {(k <= 11 && k != 8), (k == 8)});
      end
      checks++;
      if (bus.host_rvalid !== (k == 10)) begin
        errors++;
        $display("FAIL starve_host_rvalid: cycle %0d got %b want %b", k, bus.host_rvalid, (k == 10));
      end
      if (k == 10) begin
        exp_d = exp_word(10'd64, 9'd5);
        checks++;
        if (bus.host_rdata !== exp_d) begin
          errors++;
          $display("FAIL starve_host_rdata: got %h want %h", bus.host_rdata, exp_d);
        end
      end
      exp_sr = (k >= 2 && k != 10);
      checks++;
      if (bus.scan_rvalid !== exp_sr) begin
        errors++;
        $display("FAIL starve_scan_rvalid: cycle %0d got %b want %b", k, bus.scan_rvalid, exp_sr);
      end
      if (exp_sr) begin
        exp_d = exp_word(10'(16 * (k - 2)), 9'd40);
        checks++;
        if (bus.scan_rdata !== exp_d) begin
          errors++;
          $display("FAIL starve_scan_rdata: cycle %0d got %h want %h", k, bus.scan_rdata, exp_d);
        end
      end
    end
    idle();
  endtask

  task automatic test_starve_clear();
    for (int k = 0; k < 17; k++) begin
      next_cycle();
      bus.scan_req   = (k <= 15);
      bus.scan_y     = 9'd7;
      bus.host_valid = (k != 5 && k <= 14);
      bus.host_we    = 1'b0;
      bus.host_x     = 10'd16;
      bus.host_y     = 9'd9;
      @(negedge clk);
      checks++;
      if ({bus.scan_gnt, bus.host_ready} !== {(k <= 15 && k != 14), (k == 14)}) begin
        errors++;
        $display("FAIL starve_clear_grant: cycle %0d got %b want %b", k, {bus.scan_gnt, bus.host_ready},
                 {(k <= 15 && k != 14), (k == 14)});
      end
    end
    idle();
    repeat (3) next_cycle();
  endtask

  task automatic test_alternate();
    int          j;
    logic        exp_s;
    logic        exp_h;
    logic [15:0] exp_sd;
    logic [15:0] exp_hd;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      bus.scan_req   = (k < 6 && (k % 2) == 0);
      bus.scan_x     = 10'(16 * k);
      bus.scan_y     = 9'd200;
      bus.host_valid = (k < 6 && (k % 2) == 1);
      bus.host_we    = 1'b0;
      bus.host_x     = 10'(32 * k);
      bus.host_y     = 9'd300;
      @(negedge clk);
      checks++;
      if ({bus.scan_gnt, bus.host_ready} !== {(k < 6 && (k % 2) == 0), (k < 6 && (k % 2) == 1)}) begin
        errors++;
        $display("FAIL alt_grant: cycle %0d got %b", k, {bus.scan_gnt, bus.host_ready});
      end
      j      = k - 2;
      exp_s  = (j >= 0 && j < 6 && (j % 2) == 0);
      exp_h  = (j >= 0 && j < 6 && (j % 2) == 1);
      exp_sd = exp_s ? exp_word(10'(16 * j), 9'd200) : 16'h0;
      exp_hd = exp_h ? exp_word(10'(32 * j), 9'd300) : 16'h0;
      checks++;
      if ({bus.scan_rvalid, bus.host_rvalid} !== {exp_s, exp_h}) begin
        errors++;
        $display("FAIL alt_rvalid: cycle %0d got %b want %b", k, {bus.scan_rvalid, bus.host_rvalid},
                 {exp_s, exp_h});
      end
      checks++;
      if ({bus.scan_rdata, bus.host_rdata} !== {exp_sd, exp_hd}) begin
        errors++;
        $display("FAIL alt_rdata: cycle %0d got %h want %h", k, {bus.scan_rdata, bus.host_rdata},
                 {exp_sd, exp_hd});
      end
    end
    idle();
  endtask

`ifdef FB_ARB_STATS_EN
  task automatic test_stats();
    next_cycle();
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.scan_req   = 1'b1;
      bus.scan_y     = 9'd3;
      bus.host_valid = 1'b1;
      bus.host_we    = 1'b0;
      bus.host_y     = 9'd4;
      next_cycle();
    end
    idle();
    @(negedge clk);
    checks++;
    if (stat_conflict_cnt !== 16'd10) begin
      errors++;
      $display("FAIL stats_conflict: got %0d want 10", stat_conflict_cnt);
    end
    checks++;
    if ({stat_scan_cnt, stat_host_cnt} !== {16'd9, 16'd1}) begin
      errors++;
      $display("FAIL stats_grants: got %0d/%0d want 9/1", stat_scan_cnt, stat_host_cnt);
    end
    next_cycle();
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({stat_scan_cnt, stat_host_cnt, stat_conflict_cnt} !== 48'h0) begin
      errors++;
      $display("FAIL stats_clear: got %h want 0", {stat_scan_cnt, stat_host_cnt, stat_conflict_cnt});
    end
  endtask
`endif

  // Test sequence and final report.
  initial begin
    idle();
    test_reset();
    test_scan_stream();
    test_host_write();
    test_starve();
    test_starve_clear();
    test_alternate();
`ifdef FB_ARB_STATS_EN
    test_stats();
`endif
    repeat (2) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule
